seg7_capture: RTL and testbench
===============================

Name: seg7_capture

Overview:
- Receive-side counterpart of the digit-to-segment encoder.
- Samples a multiplexed, active-low 7-segment bus (segment lines plus one-hot digit select) and decodes each pattern back to a 4-bit digit code.
- Filters glitches with a stability counter and stores one digit per display position.
- Signals when a full frame has been captured.
- Used as a display monitor/self-check for the stopwatch outputs and as a bench-side decoder.

Parameters:
- NUM_DIGITS, 6, number of display positions (HEX0..HEX5).
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is committed (legal range >=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- seg_in  in  7  active-low segment lines; bit 0 = segment a ... bit 6 = segment g.
- sel_in  in  NUM_DIGITS  one-hot, active-high digit select.
- err_clr  in  1  clears the sticky error flag.
- digits_out  out  4*NUM_DIGITS  decoded codes; slot i occupies bits [4i+3:4i].
- frame_valid  out  1  one-cycle pulse when every slot has been committed since the last pulse.
- err  out  1  sticky flag: an unrecognised pattern was committed.
- err_digit  out  $clog2(NUM_DIGITS)  slot index of the most recent invalid commit.

Behaviour:
- Reset values (async):
  - sync stages: seg = 7'h7F, sel = 0.
  - every digits_out slot = 4'hF (blank).
  - frame_valid = 0, err = 0, err_digit = 0.
  - written mask = 0, stability counter = 0.
- Input path:
  - seg_in and sel_in pass through a 2-flop synchroniser.
  - All logic below uses only the stage-2 pair (seg, sel).
- Decode table (active-low pattern -> code):
  - 7'h40->0, 7'h79->1, 7'h24->2, 7'h30->3, 7'h19->4.
  - 7'h12->5, 7'h02->6, 7'h78->7, 7'h00->8, 7'h10->9.
  - 7'h7F->4'hF (blank).
  - Any other pattern -> 4'hE (invalid).
- Stability counter:
  - Resets to 0 when the stage-2 pair differs from its value on the previous cycle.
  - Otherwise increments, saturating at STABLE_CYCLES.
- Commit timing:
  - A commit occurs on the single edge at which the counter reaches STABLE_CYCLES-1, i.e. after STABLE_CYCLES identical consecutive stage-2 samples.
  - Commit happens once per stable run; a held pattern never re-commits.
- Commit qualification:
  - Only if sel is exactly one-hot.
  - sel = 0 or multi-hot: no commit, no error, and the counter is forced to 0.
- Commit action:
  - Write the decoded code into slot index(sel).
  - Set the mask bit for that slot.
  - digits_out updates on the commit edge.
- Latency: pin change captured by stage 1 at edge k is visible on digits_out after edge k+1+STABLE_CYCLES. Patterns held fewer than STABLE_CYCLES stage-2 samples are never committed.
- Frame completion:
  - If a commit makes the mask all-ones, frame_valid = 1 on that same edge and the mask clears to 0 on that edge.
  - frame_valid deasserts on the next edge.
- Re-commit of an already-masked slot before frame completion: overwrite the value, no error.
- Invalid pattern commit:
  - Slot gets 4'hE, err is set to 1, err_digit = slot index.
  - The commit still counts toward the frame.
- err_clr:
  - Clears err on the next edge; err_digit is retained.
  - Simultaneous err_clr and invalid commit: set wins.
- Reset mid-frame: all state returns immediately to reset values; the partial frame is discarded.

Decomposition:
- Package seg7_pkg:
  - Pattern constants SEG_0..SEG_9 and SEG_BLANK = 7'h7F.
  - Code constants DIG_BLANK = 4'hF and DIG_INVALID = 4'hE.
  - Typedef seg_t (logic [6:0]) and typedef dig_t (logic [3:0]).
- Sub-module seg2dig: purely combinational pattern-to-code decoder, plus an is_valid output. The block instantiates it once on the stage-2 seg.

Test Plan:
- Frame capture: with STABLE_CYCLES=4, drive sel=000001..100000, each held 8 cycles, with patterns for 1,2,3,4,5,6.
  - digits_out = 24'h654321.
  - frame_valid pulses exactly once, on the sixth commit edge.
- Glitch filter: hold sel=000001 / 7'h40 for 10 cycles, then inject 7'h79 for 3 cycles, then return to 7'h40.
  - slot0 = 0 throughout; the 7'h79 glitch never commits.
- Latency: step seg_in to 7'h12 on slot 2 just before edge k.
  - slot2 changes to 5 after edge k+5 and not earlier.
- Invalid and sticky error: drive 7'h55 on slot 3 for 6 cycles.
  - slot3 = 4'hE, err = 1, err_digit = 3.
  - Assert err_clr on the same edge as a second invalid commit: err stays 1.
  - A lone err_clr afterwards clears err.
- Select faults: sel=0 for 10 cycles, then sel=000011 with 7'h00 for 10 cycles.
  - No commits, err = 0, mask unchanged, all slots remain 4'hF.
- Reset mid-frame: commit slots 0-2, then pulse rst_n low asynchronously between edges.
  - All slots read 4'hF immediately, frame_valid = 0.
  - A following full frame needs all six commits before frame_valid pulses.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment capture path.
// Segment patterns are active-low, bit 0 = segment a ... bit 6 = segment g.
package seg7_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] dig_t;

    localparam seg_t SEG_0     = 7'h40;
    localparam seg_t SEG_1     = 7'h79;
    localparam seg_t SEG_2     = 7'h24;
    localparam seg_t SEG_3     = 7'h30;
    localparam seg_t SEG_4     = 7'h19;
    localparam seg_t SEG_5     = 7'h12;
    localparam seg_t SEG_6     = 7'h02;
    localparam seg_t SEG_7     = 7'h78;
    localparam seg_t SEG_8     = 7'h00;
    localparam seg_t SEG_9     = 7'h10;
    localparam seg_t SEG_BLANK = 7'h7F;

    localparam dig_t DIG_BLANK   = 4'hF;
    localparam dig_t DIG_INVALID = 4'hE;

endpackage

// File: rtl/seg2dig.sv
// Combinational decoder from an active-low segment pattern back to a digit code.
// Blank is a recognised pattern; anything outside the table is flagged invalid.
module seg2dig
    import seg7_pkg::*;
(
    input  seg_t seg,
    output dig_t dig,
    output logic is_valid
);

    always_comb begin
        dig      = DIG_INVALID;
        is_valid = 1'b1;
        case (seg)
            SEG_0:     dig = 4'd0;
            SEG_1:     dig = 4'd1;
            SEG_2:     dig = 4'd2;
            SEG_3:     dig = 4'd3;
            SEG_4:     dig = 4'd4;
            SEG_5:     dig = 4'd5;
            SEG_6:     dig = 4'd6;
            SEG_7:     dig = 4'd7;
            SEG_8:     dig = 4'd8;
            SEG_9:     dig = 4'd9;
            SEG_BLANK: dig = DIG_BLANK;
            default:   is_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// Samples a multiplexed 7-segment bus, filters glitches and stores one decoded
// digit per display position, pulsing frame_valid once every slot has been written.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 6,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [6:0]                    seg_in,
    input  logic [NUM_DIGITS-1:0]         sel_in,
    input  logic                          err_clr,
    output logic [4*NUM_DIGITS-1:0]       digits_out,
    output logic                          frame_valid,
    output logic                          err,
    output logic [$clog2(NUM_DIGITS)-1:0] err_digit
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] COMMIT_AT = CNT_W'(STABLE_CYCLES - 1);

    seg_t                  seg_s1, seg_s2, seg_prev;
    logic [NUM_DIGITS-1:0] sel_s1, sel_s2, sel_prev;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic [NUM_DIGITS-1:0] mask, mask_next;
    logic [IDX_W-1:0]      commit_idx;
    logic                  pair_changed, sel_onehot, commit, frame_done;
    dig_t                  dig;
    logic                  is_valid;

    seg2dig u_seg2dig (
        .seg      (seg_s2),
        .dig      (dig),
        .is_valid (is_valid)
    );

    // Commit fires only on the edge where the run length first reaches
    // STABLE_CYCLES-1, so a held pattern is written exactly once.
    always_comb begin
        pair_changed = (seg_s2 != seg_prev) || (sel_s2 != sel_prev);
        sel_onehot   = (sel_s2 != '0) && ((sel_s2 & (sel_s2 - NUM_DIGITS'(1))) == '0);
        if (!sel_onehot || pair_changed) begin
            cnt_next = '0;
        end else if (cnt == CNT_MAX) begin
            cnt_next = cnt;
        end else begin
            cnt_next = cnt + CNT_W'(1);
        end
        commit     = sel_onehot && (cnt_next == COMMIT_AT) && (pair_changed || cnt != COMMIT_AT);
        mask_next  = mask | sel_s2;
        frame_done = commit && (&mask_next);
        commit_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_s2[i]) begin
                commit_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1   <= SEG_BLANK;
            seg_s2   <= SEG_BLANK;
            seg_prev <= SEG_BLANK;
            sel_s1   <= '0;
            sel_s2   <= '0;
            sel_prev <= '0;
            cnt      <= '0;
        end else begin
            seg_s1   <= seg_in;
            seg_s2   <= seg_s1;
            seg_prev <= seg_s2;
            sel_s1   <= sel_in;
            sel_s2   <= sel_s1;
            sel_prev <= sel_s2;
            cnt      <= cnt_next;
        end
    end

    // An invalid commit still counts toward the frame; error set beats err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_out  <= '1;
            mask        <= '0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
            err_digit   <= '0;
        end else begin
            frame_valid <= frame_done;
            if (frame_done) begin
                mask <= '0;
            end else if (commit) begin
                mask <= mask_next;
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (commit && sel_s2[i]) begin
                    digits_out[4*i +: 4] <= dig;
                end
            end
            if (commit && !is_valid) begin
                err       <= 1'b1;
                err_digit <= commit_idx;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture: directed scenarios plus random bus traffic
// compared every cycle against a run-length reference model of the capture rules.
module tb_seg7_capture;

    localparam int NUM_DIGITS = 6;
    localparam int STABLE     = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [6:0]            seg_in;
    logic [NUM_DIGITS-1:0] sel_in;
    logic                  err_clr;
    logic [4*NUM_DIGITS-1:0] digits_out;
    logic                  frame_valid;
    logic                  err;
    logic [2:0]            err_digit;

    int checks = 0;
    int fails  = 0;
    int fvCount = 0;

    logic [6:0] patTable [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Reference model state: pin history window plus the architectural results.
    logic [6:0]            histSeg [$];
    logic [NUM_DIGITS-1:0] histSel [$];
    logic [3:0]            expDig [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] expMask;
    logic                  expErr;
    logic                  expFv;
    logic [2:0]            expErrDigit;

    seg7_capture #(
        .NUM_DIGITS    (NUM_DIGITS),
        .STABLE_CYCLES (STABLE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .sel_in      (sel_in),
        .err_clr     (err_clr),
        .digits_out  (digits_out),
        .frame_valid (frame_valid),
        .err         (err),
        .err_digit   (err_digit)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [3:0] decodeRef(input logic [6:0] p);
        for (int d = 0; d < 10; d++) begin
            if (patTable[d] == p) return 4'(d);
        end
        if (p == 7'h7F) return 4'hF;
        return 4'hE;
    endfunction

    function automatic logic [4*NUM_DIGITS-1:0] packDigits();
        logic [4*NUM_DIGITS-1:0] r;
        for (int i = 0; i < NUM_DIGITS; i++) r[4*i +: 4] = expDig[i];
        return r;
    endfunction

    task automatic modelReset();
        histSeg.delete();
        histSel.delete();
        for (int i = 0; i < STABLE + 2; i++) begin
            histSeg.push_back(7'h7F);
            histSel.push_back('0);
        end
        for (int i = 0; i < NUM_DIGITS; i++) expDig[i] = 4'hF;
        expMask     = '0;
        expErr      = 1'b0;
        expFv       = 1'b0;
        expErrDigit = '0;
    endtask

    // A pin value captured at edge k is written at edge k+1+STABLE when it was
    // held for STABLE captures, differed from the capture before, and sel was one-hot.
    task automatic modelEdge();
        logic runOk, fresh;
        int slot;
        logic [3:0] code;
        histSeg.push_back(seg_in);
        histSel.push_back(sel_in);
        while (histSeg.size() > STABLE + 3) begin
            void'(histSeg.pop_front());
            void'(histSel.pop_front());
        end
        runOk = 1'b1;
        for (int j = 2; j <= STABLE; j++) begin
            if (histSeg[j] != histSeg[1] || histSel[j] != histSel[1]) runOk = 1'b0;
        end
        fresh = (histSeg[0] != histSeg[1]) || (histSel[0] != histSel[1]);
        expFv = 1'b0;
        if (err_clr) expErr = 1'b0;
        if (runOk && fresh && $countones(histSel[1]) == 1) begin
            slot = 0;
            for (int i = 0; i < NUM_DIGITS; i++) if (histSel[1][i]) slot = i;
            code = decodeRef(histSeg[1]);
            expDig[slot] = code;
            if (code == 4'hE) begin
                expErr      = 1'b1;
                expErrDigit = 3'(slot);
            end
            expMask = expMask | histSel[1];
            if (&expMask) begin
                expFv   = 1'b1;
                expMask = '0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("digits", 32'(digits_out), 32'(packDigits()));
        checkOutput("frame_valid", 32'(frame_valid), 32'(expFv));
        checkOutput("err", 32'(err), 32'(expErr));
        checkOutput("err_digit", 32'(err_digit), 32'(expErrDigit));
        if (frame_valid) fvCount++;
    endtask

    task automatic applyStimulus(input logic [6:0] s, input logic [NUM_DIGITS-1:0] d, input int cycles);
        seg_in = s;
        sel_in = d;
        repeat (cycles) tick();
    endtask

    initial begin
        logic [6:0] rs;
        logic [NUM_DIGITS-1:0] rd;
        int r;

        rst_n   = 1'b0;
        seg_in  = 7'h7F;
        sel_in  = '0;
        err_clr = 1'b0;
        modelReset();
        #12;
        checkOutput("rst_digits", 32'(digits_out), 32'h00FF_FFFF);
        checkOutput("rst_frame_valid", 32'(frame_valid), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_err_digit", 32'(err_digit), 32'd0);
        rst_n = 1'b1;

        // Select faults: nothing may commit.
        applyStimulus(7'h40, 6'b000000, 10);
        applyStimulus(7'h00, 6'b000011, 10);
        checkOutput("selfault_digits", 32'(digits_out), 32'h00FF_FFFF);
        checkOutput("selfault_err", 32'(err), 32'd0);

        // Full frame 1..6.
        fvCount = 0;
        for (int i = 0; i < NUM_DIGITS; i++) applyStimulus(patTable[i+1], 6'(1 << i), 8);
        checkOutput("frame_digits", 32'(digits_out), 32'h0065_4321);
        checkOutput("frame_pulses", 32'(fvCount), 32'd1);

        // Glitch shorter than the filter window.
        applyStimulus(7'h40, 6'b000001, 10);
        seg_in = 7'h79;
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput("glitch_slot0", 32'(digits_out[3:0]), 32'd0);
        end
        seg_in = 7'h40;
        for (int c = 0; c < 8; c++) begin
            tick();
            checkOutput("glitch_slot0", 32'(digits_out[3:0]), 32'd0);
        end

        // Latency: captured at edge k, visible after edge k+5.
        seg_in = 7'h12;
        sel_in = 6'b000100;
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput("latency_early", 32'(digits_out[11:8]), 32'd3);
        end
        tick();
        checkOutput("latency_commit", 32'(digits_out[11:8]), 32'd5);
        repeat (2) tick();

        // Invalid pattern and sticky error.
        applyStimulus(7'h55, 6'b001000, 6);
        checkOutput("inv_slot3", 32'(digits_out[15:12]), 32'hE);
        checkOutput("inv_err", 32'(err), 32'd1);
        checkOutput("inv_err_digit", 32'(err_digit), 32'd3);
        seg_in = 7'h56;
        repeat (5) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("inv_set_wins", 32'(err), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("inv_clr", 32'(err), 32'd0);
        checkOutput("inv_clr_digit", 32'(err_digit), 32'd3);
        tick();

        // Reset mid-frame, then a full frame must be needed again.
        for (int i = 0; i < 3; i++) applyStimulus(patTable[7+i], 6'(1 << i), 6);
        sel_in = '0;
        seg_in = 7'h7F;
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("midrst_digits", 32'(digits_out), 32'h00FF_FFFF);
        checkOutput("midrst_frame_valid", 32'(frame_valid), 32'd0);
        #1;
        rst_n = 1'b1;
        fvCount = 0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            applyStimulus(patTable[9-i], 6'(1 << i), 6);
            if (i == NUM_DIGITS - 2) checkOutput("midrst_no_early_frame", 32'(fvCount), 32'd0);
        end
        checkOutput("midrst_frame_pulses", 32'(fvCount), 32'd1);
        checkOutput("midrst_frame_digits", 32'(digits_out), 32'h0045_6789);

        // Random bus traffic against the reference model.
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       rs = patTable[$urandom_range(0, 9)];
            else if (r == 7) rs = 7'h7F;
            else             rs = 7'($urandom);
            r = $urandom_range(0, 9);
            if (r < 8)       rd = 6'(1 << $urandom_range(0, NUM_DIGITS - 1));
            else if (r == 8) rd = '0;
            else             rd = 6'($urandom);
            err_clr = ($urandom_range(0, 9) == 0);
            applyStimulus(rs, rd, $urandom_range(1, 8));
        end
        err_clr = 1'b0;
        applyStimulus(7'h7F, '0, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
